// File: rtl/stopwatch_counter.sv
// Stopwatch core: run/pause/clear FSM, BCD MM:SS live count, lap-hold display
// and a rollover pulse when the count wraps to 00:00.
module stopwatch_counter #(
  parameter int MINUTE_LIMIT = 60
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       second_tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       timer_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       lap_active,
  output logic       rollover
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  localparam logic [3:0] LIM_TENS = 4'((MINUTE_LIMIT - 1) / 10);
  localparam logic [3:0] LIM_ONES = 4'((MINUTE_LIMIT - 1) % 10);

  state_t      state_q, state_d;
  logic        ss_prev_q, ss_prev_d;
  logic        clr_prev_q, clr_prev_d;
  logic        lap_prev_q, lap_prev_d;
  logic [15:0] live_q, live_d;
  logic [15:0] lap_val_q, lap_val_d;
  logic        lap_active_q, lap_active_d;
  logic [15:0] disp_q, disp_d;
  logic        rollover_q, rollover_d;

  logic        ss_edge, clr_edge, lap_edge;
  logic [3:0]  inc_mt, inc_mo, inc_st, inc_so;
  logic [15:0] live_inc;
  logic        wrap;

  assign ss_edge  = start_stop & ~ss_prev_q;
  assign clr_edge = clear & ~clr_prev_q;
  assign lap_edge = lap & ~lap_prev_q;

  // Live count plus one second, digit packing {min_tens, min_ones, sec_tens, sec_ones}
  always_comb begin
    {inc_mt, inc_mo, inc_st, inc_so} = live_q;
    wrap = 1'b0;
    if (inc_so == 4'd9) begin
      inc_so = 4'd0;
      if (inc_st == 4'd5) begin
        inc_st = 4'd0;
        if (inc_mt == LIM_TENS && inc_mo == LIM_ONES) begin
          inc_mt = 4'd0;
          inc_mo = 4'd0;
          wrap   = 1'b1;
        end else if (inc_mo == 4'd9) begin
          inc_mo = 4'd0;
          inc_mt = inc_mt + 4'd1;
        end else begin
          inc_mo = inc_mo + 4'd1;
        end
      end else begin
        inc_st = inc_st + 4'd1;
      end
    end else begin
      inc_so = inc_so + 4'd1;
    end
    live_inc = {inc_mt, inc_mo, inc_st, inc_so};
  end

  always_comb begin
    state_d      = state_q;
    live_d       = live_q;
    lap_val_d    = lap_val_q;
    lap_active_d = lap_active_q;
    rollover_d   = 1'b0;
    ss_prev_d    = start_stop;
    clr_prev_d   = clear;
    lap_prev_d   = lap;

    if (clr_edge) begin
      state_d      = IDLE;
      live_d       = 16'h0000;
      lap_active_d = 1'b0;
    end else begin
      // Lap and tick both look at the pre-transition state and pre-increment count
      if (lap_edge) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q == RUNNING) begin
          lap_val_d    = live_q;
          lap_active_d = 1'b1;
        end
      end
      if (state_q == RUNNING && second_tick) begin
        live_d     = live_inc;
        rollover_d = wrap;
      end
      if (ss_edge) begin
        case (state_q)
          IDLE:    state_d = RUNNING;
          RUNNING: state_d = PAUSED;
          PAUSED:  state_d = RUNNING;
          default: state_d = IDLE;
        endcase
      end
    end

    disp_d = lap_active_d ? lap_val_d : live_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      ss_prev_q    <= 1'b0;
      clr_prev_q   <= 1'b0;
      lap_prev_q   <= 1'b0;
      live_q       <= 16'h0000;
      lap_val_q    <= 16'h0000;
      lap_active_q <= 1'b0;
      disp_q       <= 16'h0000;
      rollover_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_prev_q    <= ss_prev_d;
      clr_prev_q   <= clr_prev_d;
      lap_prev_q   <= lap_prev_d;
      live_q       <= live_d;
      lap_val_q    <= lap_val_d;
      lap_active_q <= lap_active_d;
      disp_q       <= disp_d;
      rollover_q   <= rollover_d;
    end
  end

  assign timer_enable = (state_q == RUNNING);
  assign min_tens     = disp_q[15:12];
  assign min_ones     = disp_q[11:8];
  assign sec_tens     = disp_q[7:4];
  assign sec_ones     = disp_q[3:0];
  assign lap_active   = lap_active_q;
  assign rollover     = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (60- and 10-minute limits) share stimulus
// and are compared every cycle against a seconds-based reference model.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic second_tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  wire        te0, te1, la0, la1, ro0, ro1;
  wire [15:0] disp0, disp1;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model: state 0=idle 1=running 2=paused, times in whole seconds
  int m_state[2];
  int m_live[2];
  int m_lap[2];
  bit m_lap_act[2];
  bit m_roll[2];
  bit p_ss, p_clr, p_lap;

  stopwatch_counter #(.MINUTE_LIMIT(60)) u_dut60 (
    .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .timer_enable(te0),
    .min_tens(disp0[15:12]), .min_ones(disp0[11:8]), .sec_tens(disp0[7:4]), .sec_ones(disp0[3:0]),
    .lap_active(la0), .rollover(ro0)
  );

  stopwatch_counter #(.MINUTE_LIMIT(10)) u_dut10 (
    .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .timer_enable(te1),
    .min_tens(disp1[15:12]), .min_ones(disp1[11:8]), .sec_tens(disp1[7:4]), .sec_ones(disp1[3:0]),
    .lap_active(la1), .rollover(ro1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] toBcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_live[i] = 0; m_lap[i] = 0; m_lap_act[i] = 0; m_roll[i] = 0;
    end
    p_ss = 0; p_clr = 0; p_lap = 0;
  endtask

  task automatic modelStep(input bit ss, input bit clr, input bit lp, input bit tk);
    bit ss_e, clr_e, lap_e;
    int lim, old_state;
    ss_e  = ss && !p_ss;
    clr_e = clr && !p_clr;
    lap_e = lp && !p_lap;
    for (int i = 0; i < 2; i++) begin
      lim = (i == 0) ? 60 : 10;
      old_state = m_state[i];
      m_roll[i] = 0;
      if (clr_e) begin
        m_state[i] = 0; m_live[i] = 0; m_lap_act[i] = 0;
      end else begin
        if (lap_e) begin
          if (m_lap_act[i]) m_lap_act[i] = 0;
          else if (old_state == 1) begin
            m_lap[i] = m_live[i];
            m_lap_act[i] = 1;
          end
        end
        if (old_state == 1 && tk) begin
          m_live[i] = (m_live[i] + 1) % (lim * 60);
          if (m_live[i] == 0) m_roll[i] = 1;
        end
        if (ss_e) m_state[i] = (old_state == 1) ? 2 : 1;
      end
    end
    p_ss = ss; p_clr = clr; p_lap = lp;
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      int shown;
      shown = m_lap_act[i] ? m_lap[i] : m_live[i];
      checkOutput($sformatf("disp%0d", i), (i == 0) ? disp0 : disp1, toBcd(shown));
      checkOutput($sformatf("te%0d", i), (i == 0) ? te0 : te1, (m_state[i] == 1));
      checkOutput($sformatf("lap%0d", i), (i == 0) ? la0 : la1, m_lap_act[i]);
      checkOutput($sformatf("roll%0d", i), (i == 0) ? ro0 : ro1, m_roll[i]);
    end
  endtask

  task automatic applyStimulus(input bit ss, input bit clr, input bit lp, input bit tk);
    start_stop = ss; clear = clr; lap = lp; second_tick = tk;
    modelStep(ss, clr, lp, tk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic restartAt(input int secs);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < secs; k++) applyStimulus(0, 0, 0, 1);
  endtask

  initial begin
    bit saw_roll;
    int guard;
    int transitions;
    logic prev_te;

    modelReset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    compareAll();
    checkOutput("reset_disp", disp0, 16'h0000);
    checkOutput("reset_te", te0, 1'b0);

    // Start then 75 ticks
    applyStimulus(1, 0, 0, 0);
    saw_roll = 0;
    for (int k = 0; k < 75; k++) begin
      applyStimulus(0, 0, 0, 1);
      saw_roll |= ro0 | ro1;
    end
    checkOutput("s1_disp60", disp0, 16'h0115);
    checkOutput("s1_disp10", disp1, 16'h0115);
    checkOutput("s1_te", te0, 1'b1);
    checkOutput("s1_noroll", saw_roll, 1'b0);

    // Pause, ticks ignored, resume
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("s2_disp", disp0, 16'h0115);
    checkOutput("s2_te", te0, 1'b0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("s2_resume", te0, 1'b1);

    // Wrap of both limits
    restartAt(0);
    guard = 0;
    while (m_live[1] != 599 && guard < 5000) begin applyStimulus(0, 0, 0, 1); guard++; end
    checkOutput("s3_at959", disp1, 16'h0959);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s3_roll10", ro1, 1'b1);
    checkOutput("s3_wrap10", disp1, 16'h0000);
    guard = 0;
    while (m_live[0] != 3599 && guard < 5000) begin applyStimulus(0, 0, 0, 1); guard++; end
    checkOutput("s3_at5959", disp0, 16'h5959);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s3_roll60", ro0, 1'b1);
    checkOutput("s3_wrap60", disp0, 16'h0000);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s3_roll_once", ro0, 1'b0);

    // Lap hold
    restartAt(20);
    applyStimulus(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("s4_frozen", disp0, 16'h0020);
    checkOutput("s4_lapon", la0, 1'b1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("s4_live", disp0, 16'h0025);
    checkOutput("s4_lapoff", la0, 1'b0);

    // Clear priority, then held start_stop
    restartAt(187);
    checkOutput("s5_at307", disp0, 16'h0307);
    applyStimulus(1, 1, 0, 1);
    checkOutput("s5_disp", disp0, 16'h0000);
    checkOutput("s5_te", te0, 1'b0);
    applyStimulus(0, 0, 0, 0);
    transitions = 0;
    prev_te = te0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1, 0, 0, 0);
      if (te0 !== prev_te) transitions++;
      prev_te = te0;
    end
    checkOutput("s5_one_event", transitions, 1);

    // Randomized mix
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 7) == 0) ? !start_stop : start_stop,
                    ($urandom_range(0, 40) == 0),
                    ($urandom_range(0, 7) == 0) ? !lap : lap,
                    $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset between clock edges
    restartAt(13);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("s6_disp60", disp0, 16'h0000);
    checkOutput("s6_disp10", disp1, 16'h0000);
    checkOutput("s6_te", te0, 1'b0);
    checkOutput("s6_lap", la0, 1'b0);
    checkOutput("s6_roll", ro0, 1'b0);
    start_stop = 0; clear = 0; lap = 0; second_tick = 0;
    modelReset();
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
